gcd_result_display: RTL
=======================

# gcd_result_display

Output stage placed directly downstream of the GCD processor. It watches the processor's `Halt` flag and captures the 8-bit `Output` result on the rising edge of `Halt`. The result is converted to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and the digits are driven onto a time-multiplexed 3-digit seven-segment display. The previous result stays on the display until a new conversion completes.

## Interface
- `SCAN_DIV`, default 1024: clock cycles each digit is enabled during scanning; legal range ≥ 2.
- `BLANK_LEADING`, default 1: when 1, leading zero digits are blanked; the units digit is never blanked.

- `Clock`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Halt`  in  1  processor done flag, level.
- `Result`  in  8  processor `Output`, unsigned, 0–255.
- `Busy`  out  1  high while a conversion is running.
- `Valid`  out  1  high once at least one conversion has completed.
- `Bcd`  out  12  {hundreds, tens, units}, 4 bits each.
- `Seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `DigitEn`  out  3  digit enables {hundreds, tens, units}, active-low.

## Operation
- **Reset values:** `Busy`=0, `Valid`=0, `Bcd`=12'h000, `Seg`=7'h7F, `DigitEn`=3'b111, state IDLE, scan counter and digit index 0.
- **Halt registration:** `Halt` is registered into `halt_q`. A start event is `Halt`=1 while `halt_q`=0. A `Halt` level held high does not retrigger.
- **IDLE:** on a start event, latch `Result` into the shift register, clear the BCD accumulator, clear the iteration count, go to CONVERT.
- **CONVERT:** one iteration per cycle, 8 iterations.
  - Each iteration: first add 3 to every BCD nibble that is ≥5, then shift {accumulator, shift register} left by 1.
  - After iteration 8: write the accumulator to `Bcd`, set `Valid`=1, go to SHOW.
  - Start events during CONVERT are ignored.
- **SHOW:** on a start event, re-capture and go to CONVERT. During this conversion `Bcd`, `Valid` and the scan keep their old values.
- **Scanning:** runs whenever `Valid`=1.
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→0 (units, tens, hundreds).
  - The digit index is 0 when `Valid` first rises.
  - The active digit drives its `DigitEn` bit low, and `Seg` shows that digit's glyph.
- **Blanking** (`BLANK_LEADING`=1):
  - Hundreds is blanked when it is 0.
  - Tens is blanked when both hundreds and tens are 0.
  - A blanked digit slot drives `DigitEn`=3'b111 and `Seg`=7'h7F, but still uses its full scan time slot.
- **Glyphs:** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. A nibble >9 cannot occur; if one does, drive 7'h7F.
- **Width rule:** the accumulator is 12 bits. The maximum result 255 yields 12'h255 with no overflow.

## Timing
- A start event is sampled at edge k. CONVERT runs on edges k+1..k+8.
- `Bcd` and `Valid` update at edge k+8, giving 8 cycles of latency from capture.
- `Busy` is high after edge k through edge k+8 and low after edge k+8.
- Minimum spacing between accepted results is 9 cycles.
- `Seg` and `DigitEn` are registered: they change one cycle after the digit index changes.
- **Reset mid-operation:** all outputs return to reset values immediately, with no clock needed. A conversion in progress is discarded.
- A start event and a scan wrap in the same cycle are both honoured; they are independent.

## Structure
- **Shared package `gcd_disp_pkg`:**
  - state enum {IDLE, CONVERT, SHOW};
  - the 10 glyph constants plus `SEG_BLANK`=7'h7F;
  - `DIGIT_OFF`=3'b111.
- **Sub-module `gcd_seg_decode`:** combinational, 4-bit nibble → 7-bit active-low glyph; used once on the muxed digit.
- **Top-level contents:** FSM, double-dabble datapath, scan counter, blanking logic.

## Test plan
- **Reset:** assert `Reset`=0 mid-run → `Seg`=7'h7F, `DigitEn`=3'b111, `Valid`=0, `Busy`=0, `Bcd`=12'h000 immediately.
- **Full-scale conversion:** `Result`=255, `Halt` 0→1 at edge k → `Busy`=1 for 8 cycles, `Bcd`=12'h255 and `Valid`=1 after edge k+8.
- **Blanking and scan:** `SCAN_DIV`=4, `Result`=6 → `Bcd`=12'h006. Units slot shows `DigitEn`=3'b110, `Seg`=0000010 for 4 cycles. Tens and hundreds slots show `DigitEn`=3'b111 for 4 cycles each. The sequence repeats.
- **Zero result:** `Result`=0 → `Bcd`=12'h000, units shows glyph 1000000.
- **Retrigger ignored:** `Result`=48 captured, then `Halt` pulsed 0→1 again with `Result`=9 during CONVERT → `Bcd`=12'h048. Holding `Halt` high afterwards causes no new conversion.
- **Reset during CONVERT:** `Reset` pulsed low at cycle 4 of CONVERT with `Result`=200 → `Valid` stays 0. A later start with `Result`=200 → `Bcd`=12'h200; tens and units are shown, because only leading zeros are blanked.

Source files
------------

// File: rtl/gcd_disp_pkg.sv
// Shared types and constants for the GCD result display stage:
// FSM states, active-low seven-segment glyphs and the double-dabble nibble adjust.
package gcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_t;

    // Glyphs are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] DIGIT_OFF = 3'b111;

    localparam int CONV_ITERS = 8;

    function automatic logic [3:0] dd_adjust(input logic [3:0] i_nibble);
        return (i_nibble >= 4'd5) ? i_nibble + 4'd3 : i_nibble;
    endfunction

endpackage

// File: rtl/gcd_seg_decode.sv
// Combinational BCD nibble to active-low seven-segment glyph.
// Codes above 9 should never reach here; they light nothing.
module gcd_seg_decode
    import gcd_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/gcd_result_display.sv
// Captures the GCD processor result on the rising edge of Halt, converts it to
// BCD with a serial double-dabble engine and scans it onto a 3-digit display.
module gcd_result_display
    import gcd_disp_pkg::*;
#(
    parameter int SCAN_DIV      = 1024,
    parameter bit BLANK_LEADING = 1'b1
)
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Halt,
    input  logic [7:0]  Result,
    output logic        Busy,
    output logic        Valid,
    output logic [11:0] Bcd,
    output logic [6:0]  Seg,
    output logic [2:0]  DigitEn,
    output logic [1:0]  o_dbg_state
);

    localparam int              CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]      ITER_LAST = 3'(CONV_ITERS - 1);

    state_t         r_state;
    state_t         w_state_next;

    logic           r_halt_q;
    logic [7:0]     r_shift;
    logic [11:0]    r_acc;
    logic [2:0]     r_iter;
    logic [11:0]    r_bcd;
    logic           r_valid;

    logic [CW-1:0]  r_scan_cnt;
    logic [1:0]     r_digit;
    logic [6:0]     r_seg;
    logic [2:0]     r_digit_en;

    logic           w_start;
    logic           w_capture;
    logic           w_last_iter;
    logic [11:0]    w_acc_adj;
    logic [11:0]    w_acc_next;
    logic [7:0]     w_shift_next;
    logic [3:0]     w_nibble;
    logic [2:0]     w_en_on;
    logic           w_blank;
    logic [6:0]     w_glyph;

    // A level held high on Halt only counts once: the edge is what matters.
    assign w_start     = Halt & ~r_halt_q;
    assign w_capture   = w_start && (r_state != CONVERT);
    assign w_last_iter = (r_state == CONVERT) && (r_iter == ITER_LAST);

    assign w_acc_adj = {dd_adjust(r_acc[11:8]), dd_adjust(r_acc[7:4]), dd_adjust(r_acc[3:0])};
    assign {w_acc_next, w_shift_next} = {w_acc_adj, r_shift} << 1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start)     w_state_next = CONVERT;
            CONVERT: if (w_last_iter) w_state_next = SHOW;
            SHOW:    if (w_start)     w_state_next = CONVERT;
            default:                  w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Busy        = 1'b0;
        o_dbg_state = r_state;
        if (r_state == CONVERT) begin
            Busy = 1'b1;
        end
    end

    // ---------------- Capture and double-dabble datapath ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_halt_q <= 1'b0;
            r_shift  <= 8'd0;
            r_acc    <= 12'd0;
            r_iter   <= 3'd0;
            r_bcd    <= 12'd0;
            r_valid  <= 1'b0;
        end else begin
            r_halt_q <= Halt;
            if (w_capture) begin
                r_shift <= Result;
                r_acc   <= 12'd0;
                r_iter  <= 3'd0;
            end else if (r_state == CONVERT) begin
                r_shift <= w_shift_next;
                r_acc   <= w_acc_next;
                r_iter  <= r_iter + 3'd1;
                // The displayed value only changes once the new one is complete.
                if (w_last_iter) begin
                    r_bcd   <= w_acc_next;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    // ---------------- Scan counter and digit index ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
        end else if (!r_valid) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_digit    <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // ---------------- Digit mux and leading-zero blanking ----------------
    always_comb begin
        w_nibble = r_bcd[3:0];
        w_en_on  = 3'b110;
        w_blank  = 1'b0;
        case (r_digit)
            2'd1: begin
                w_nibble = r_bcd[7:4];
                w_en_on  = 3'b101;
                w_blank  = BLANK_LEADING && (r_bcd[11:4] == 8'd0);
            end
            2'd2: begin
                w_nibble = r_bcd[11:8];
                w_en_on  = 3'b011;
                w_blank  = BLANK_LEADING && (r_bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
    end

    gcd_seg_decode u_seg_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    // A blanked slot still occupies its full scan period; it just lights nothing.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_seg      <= SEG_BLANK;
            r_digit_en <= DIGIT_OFF;
        end else if (!r_valid || w_blank) begin
            r_seg      <= SEG_BLANK;
            r_digit_en <= DIGIT_OFF;
        end else begin
            r_seg      <= w_glyph;
            r_digit_en <= w_en_on;
        end
    end

    assign Valid   = r_valid;
    assign Bcd     = r_bcd;
    assign Seg     = r_seg;
    assign DigitEn = r_digit_en;

endmodule
